// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - state encoding, response codes and select-width helper shared by the APB master
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } apb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int sel_w_f(input int num_slaves);
      return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps the address field above SLV_SEL_LSB to a slave index, one-hot PSEL mask and decode error
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 32,
   parameter  int NUM_SLAVES  = 4,
   parameter  int SLV_SEL_LSB = 12,
   localparam int SEL_W       = sel_w_f(NUM_SLAVES),
   localparam int FIELD_W     = ADDR_WIDTH - SLV_SEL_LSB
) (
   input  logic [FIELD_W-1:0]    addr_i,
   output logic [SEL_W-1:0]      idx_o,
   output logic [NUM_SLAVES-1:0] psel_mask_o,
   output logic                  decode_err_o
);

   logic upper_nz;
   logic idx_oor;

   assign idx_o = addr_i[SEL_W-1:0];

   always_comb begin
      upper_nz = 1'b0;
      for (int b = SEL_W; b < FIELD_W; b++) begin
         upper_nz = upper_nz | addr_i[b];
      end
   end

   // Only a non-power-of-two slave count leaves unused index codes.
   if (NUM_SLAVES < (1 << SEL_W)) begin : g_idx_range
      localparam logic [SEL_W-1:0] NUM_SLAVES_W = SEL_W'(NUM_SLAVES);
      assign idx_oor = (idx_o >= NUM_SLAVES_W);
   end else begin : g_idx_full
      assign idx_oor = 1'b0;
   end

   assign decode_err_o = upper_nz | idx_oor;

   always_comb begin
      psel_mask_o = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         psel_mask_o[i] = !decode_err_o && (idx_o == SEL_W'(i));
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB4 master sequencer (IDLE/SETUP/ACCESS/DONE) with per-slave PSEL
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 32,
   parameter  int DATA_WIDTH     = 32,
   parameter  int NUM_SLAVES     = 4,
   parameter  int SLV_SEL_LSB    = 12,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int SEL_W          = sel_w_f(NUM_SLAVES)
) (
   input  logic                             ACLK,
   input  logic                             ARESETn,
   input  logic                             transfer,
   input  logic                             read,
   input  logic                             write,
   input  logic [ADDR_WIDTH-1:0]            apb_waddr,
   input  logic [ADDR_WIDTH-1:0]            apb_raddr,
   input  logic [DATA_WIDTH-1:0]            apb_wdata,
   input  logic [3:0]                       apb_strb,
   output logic [DATA_WIDTH-1:0]            apb_rdata,
   output logic                             err_flag,
   output logic                             apb_done,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic                             PWRITE,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [3:0]                       PSTRB,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   apb_state_e              state_q;
   logic [SEL_W-1:0]        idx_q;
   logic [NUM_SLAVES-1:0]   psel_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic                    done_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [3:0]              pstrb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              resp_q;

   logic                    accept;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [SEL_W-1:0]        dec_idx;
   logic [NUM_SLAVES-1:0]   dec_mask;
   logic                    dec_err;
   logic                    sel_ready;
   logic                    sel_slverr;
   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    timeout;

   assign accept   = transfer & (read | write);
   assign req_addr = write ? apb_waddr : apb_raddr;

   apb_addr_decoder #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_SLAVES  (NUM_SLAVES),
      .SLV_SEL_LSB (SLV_SEL_LSB)
   ) u_addr_decoder (
      .addr_i       (req_addr[ADDR_WIDTH-1:SLV_SEL_LSB]),
      .idx_o        (dec_idx),
      .psel_mask_o  (dec_mask),
      .decode_err_o (dec_err)
   );

   // Only the latched target slave's handshake and data are looked at.
   always_comb begin
      sel_ready  = 1'b0;
      sel_slverr = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_ready  = PREADY[i];
            sel_slverr = PSLVERR[i];
            sel_rdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic [TMO_W-1:0] tmo_cnt_d;

   // Counter reads 0 in the first ACCESS cycle; the last counted cycle still honours PREADY.
   assign tmo_cnt_d = (state_q == ST_ACCESS) ? tmo_cnt_q + 1'b1 : '0;
   assign timeout   = (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) tmo_cnt_q <= '0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         done_q    <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  paddr_q  <= req_addr;
                  pwrite_q <= write;
                  pwdata_q <= apb_wdata;
                  pstrb_q  <= write ? apb_strb : 4'h0;
                  idx_q    <= dec_idx;
                  if (dec_err) begin
                     resp_q  <= RESP_SLVERR;
                     rdata_q <= '0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     resp_q  <= RESP_OKAY;
                     psel_q  <= dec_mask;
                     state_q <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (sel_ready) begin
                  if (!pwrite_q) rdata_q <= sel_rdata;
                  resp_q    <= sel_slverr ? RESP_SLVERR : RESP_OKAY;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end else if (timeout) begin
                  resp_q    <= RESP_SLVERR;
                  rdata_q   <= '0;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign apb_rdata = rdata_q;
   assign err_flag  = (resp_q == RESP_SLVERR);
   assign apb_done  = done_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PSTRB     = pstrb_q;

endmodule
